// File: rtl/frame_demod_pkg.sv
// Shared types and default parameters for the frame demodulator.
package frame_demod_pkg;

  localparam int DEF_HEAD_LEN  = 5;
  localparam int DEF_FRAME_LEN = 32;
  localparam int DEF_REST_LEN  = 16;
  localparam int DEF_HEAD_THR  = 2;

  typedef logic signed [3:0] sample_t;

  typedef enum logic [1:0] {
    SEARCH,
    DATA,
    REST
  } state_t;

endpackage

// File: rtl/frame_demod_if.sv
// Sample input and demodulated-symbol/frame output bundle of frame_demod.
interface frame_demod_if;
  import frame_demod_pkg::*;

  sample_t     I_in;
  sample_t     Q_in;
  logic        locked;
  logic        sym_valid;
  logic        sym_I_bit;
  logic        sym_Q_bit;
  logic [4:0]  sym_idx;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic [6:0]  weak_cnt;

  modport master (
    output I_in, Q_in,
    input  locked, sym_valid, sym_I_bit, sym_Q_bit, sym_idx,
           frame_data, frame_valid, weak_cnt
  );

  modport slave (
    input  I_in, Q_in,
    output locked, sym_valid, sym_I_bit, sym_Q_bit, sym_idx,
           frame_data, frame_valid, weak_cnt
  );

endinterface

// File: rtl/iq_slicer.sv
// Per-sample combinational decisions: hard sign bits, weak flags, head qualifier.
module iq_slicer
  import frame_demod_pkg::*;
#(
  parameter int HEAD_THR = DEF_HEAD_THR
) (
  input  sample_t i_s,
  input  sample_t q_s,
  output logic    i_bit,
  output logic    q_bit,
  output logic    i_weak,
  output logic    q_weak,
  output logic    head_ok
);

  localparam sample_t THR_POS = sample_t'(HEAD_THR);
  localparam sample_t THR_NEG = sample_t'(-HEAD_THR);
  localparam sample_t WEAK_HI = sample_t'(1);
  localparam sample_t WEAK_LO = sample_t'(-1);

  // Non-negative decides 1; the sign bit alone is enough.
  assign i_bit   = ~i_s[3];
  assign q_bit   = ~q_s[3];
  assign i_weak  = (i_s >= WEAK_LO) && (i_s <= WEAK_HI);
  assign q_weak  = (q_s >= WEAK_LO) && (q_s <= WEAK_HI);
  assign head_ok = (i_s >= THR_POS) && (q_s <= THR_NEG);

endmodule

// File: rtl/frame_demod.sv
// Head-locked frame demodulator: SEARCH for a head run, slice FRAME_LEN
// data symbols into a 64-bit frame, then blank for REST_LEN cycles.
module frame_demod
  import frame_demod_pkg::*;
#(
  parameter int HEAD_LEN  = DEF_HEAD_LEN,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int REST_LEN  = DEF_REST_LEN,
  parameter int HEAD_THR  = DEF_HEAD_THR
) (
  input  logic          clk,
  input  logic          reset,
  frame_demod_if.slave  bus
);

  localparam int HW = $clog2(HEAD_LEN + 1);
  localparam int RW = $clog2(REST_LEN + 1);

  localparam logic [HW-1:0] HEAD_LAST = HW'(HEAD_LEN - 1);
  localparam logic [4:0]    SYM_LAST  = 5'(FRAME_LEN - 1);
  localparam logic [RW-1:0] REST_LAST = RW'(REST_LEN - 1);

  state_t        state;
  logic [HW-1:0] head_cnt;
  logic [4:0]    sym_cnt;
  logic [RW-1:0] rest_cnt;
  logic [63:0]   shadow;
  logic [6:0]    weak_acc;

  logic i_bit, q_bit, i_weak, q_weak, head_ok;

  iq_slicer #(.HEAD_THR(HEAD_THR)) u_slicer (
    .i_s     (bus.I_in),
    .q_s     (bus.Q_in),
    .i_bit   (i_bit),
    .q_bit   (q_bit),
    .i_weak  (i_weak),
    .q_weak  (q_weak),
    .head_ok (head_ok)
  );

  logic [63:0] shadow_next;
  logic [6:0]  weak_next;

  assign shadow_next = {shadow[61:0], i_bit, q_bit};
  assign weak_next   = weak_acc + {6'd0, i_weak} + {6'd0, q_weak};

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; the shadow register is a plain flop vector,
  // so clearing it in reset is cheap and required for a clean restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= SEARCH;
      head_cnt        <= '0;
      sym_cnt         <= '0;
      rest_cnt        <= '0;
      shadow          <= '0;
      weak_acc        <= '0;
      bus.locked      <= 1'b0;
      bus.sym_valid   <= 1'b0;
      bus.sym_I_bit   <= 1'b0;
      bus.sym_Q_bit   <= 1'b0;
      bus.sym_idx     <= '0;
      bus.frame_data  <= '0;
      bus.frame_valid <= 1'b0;
      bus.weak_cnt    <= '0;
    end else begin
      bus.sym_valid   <= 1'b0;
      bus.frame_valid <= 1'b0;
      case (state)
        SEARCH: begin
          if (!head_ok) begin
            head_cnt <= '0;
          end else if (head_cnt == HEAD_LAST) begin
            state      <= DATA;
            head_cnt   <= '0;
            sym_cnt    <= '0;
            bus.locked <= 1'b1;
          end else begin
            head_cnt <= head_cnt + 1'b1;
          end
        end
        DATA: begin
          bus.sym_valid <= 1'b1;
          bus.sym_I_bit <= i_bit;
          bus.sym_Q_bit <= q_bit;
          bus.sym_idx   <= sym_cnt;
          sym_cnt       <= sym_cnt + 1'b1;
          if (sym_cnt == SYM_LAST) begin
            bus.frame_data  <= shadow_next;
            bus.weak_cnt    <= weak_next;
            bus.frame_valid <= 1'b1;
            bus.locked      <= 1'b0;
            shadow          <= '0;
            weak_acc        <= '0;
            rest_cnt        <= '0;
            state           <= REST;
          end else begin
            shadow   <= shadow_next;
            weak_acc <= weak_next;
          end
        end
        REST: begin
          if (rest_cnt == REST_LAST) begin
            state    <= SEARCH;
            head_cnt <= '0;
          end else begin
            rest_cnt <= rest_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_demod.sv
// Directed-vector bench for frame_demod: lock, frame assembly, weak count,
// blanking, false heads, extreme samples and mid-frame reset.
module tb_frame_demod;
  import frame_demod_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_demod_if bus();

  frame_demod dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  sample_t fi [32];
  sample_t fq [32];

  task automatic drive(input sample_t i, input sample_t q);
    bus.I_in = i;
    bus.Q_in = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (bus.locked !== 1'b0 || bus.sym_valid !== 1'b0 || bus.sym_I_bit !== 1'b0 ||
        bus.sym_Q_bit !== 1'b0 || bus.frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s flags: got lk=%b sv=%b i=%b q=%b fv=%b, expected all 0", tag,
               bus.locked, bus.sym_valid, bus.sym_I_bit, bus.sym_Q_bit, bus.frame_valid);
    end
    vectors++;
    if (bus.sym_idx !== 5'd0) begin
      miscompares++;
      $display("FAIL %s sym_idx: got %0d expected 0", tag, bus.sym_idx);
    end
    vectors++;
    if (bus.frame_data !== 64'd0) begin
      miscompares++;
      $display("FAIL %s frame_data: got %h expected 0", tag, bus.frame_data);
    end
    vectors++;
    if (bus.weak_cnt !== 7'd0) begin
      miscompares++;
      $display("FAIL %s weak_cnt: got %0d expected 0", tag, bus.weak_cnt);
    end
  endtask

  // n head samples; locked must rise only after the last one when lock_last.
  task automatic heads(input int n, input logic lock_last);
    for (int k = 0; k < n; k++) begin
      logic exp_lock;
      drive(4'sd4, -4'sd4);
      exp_lock = lock_last && (k == n - 1);
      vectors++;
      if (bus.locked !== exp_lock || bus.sym_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL head[%0d]: got locked=%b sym_valid=%b expected locked=%b sym_valid=0",
                 k, bus.locked, bus.sym_valid, exp_lock);
      end
    end
  endtask

  // n samples during which nothing may be strobed or locked.
  task automatic idle(input int n, input sample_t i, input sample_t q);
    for (int k = 0; k < n; k++) begin
      drive(i, q);
      vectors++;
      if (bus.locked !== 1'b0 || bus.sym_valid !== 1'b0 || bus.frame_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle[%0d]: got locked=%b sym_valid=%b frame_valid=%b expected 0,0,0",
                 k, bus.locked, bus.sym_valid, bus.frame_valid);
      end
    end
  endtask

  // Sends fi/fq[0..nsym-1] as data; checks every strobe and, at symbol 31, the frame.
  task automatic send_frame(input int nsym, input logic [63:0] prev_data,
                            input logic [63:0] exp_data, input logic [6:0] exp_weak);
    for (int n = 0; n < nsym; n++) begin
      logic exp_i, exp_q, last;
      drive(fi[n], fq[n]);
      exp_i = (fi[n] >= 0);
      exp_q = (fq[n] >= 0);
      last  = (n == 31);
      vectors++;
      if (bus.sym_valid !== 1'b1 || bus.sym_idx !== 5'(n) ||
          bus.sym_I_bit !== exp_i || bus.sym_Q_bit !== exp_q) begin
        miscompares++;
        $display("FAIL sym[%0d]: got sv=%b idx=%0d i=%b q=%b expected sv=1 idx=%0d i=%b q=%b",
                 n, bus.sym_valid, bus.sym_idx, bus.sym_I_bit, bus.sym_Q_bit, n, exp_i, exp_q);
      end
      vectors++;
      if (bus.frame_valid !== last || bus.locked !== !last) begin
        miscompares++;
        $display("FAIL sym[%0d] strobes: got fv=%b locked=%b expected fv=%b locked=%b",
                 n, bus.frame_valid, bus.locked, last, !last);
      end
      vectors++;
      if (last) begin
        if (bus.frame_data !== exp_data || bus.weak_cnt !== exp_weak) begin
          miscompares++;
          $display("FAIL frame: got data=%h weak=%0d expected data=%h weak=%0d",
                   bus.frame_data, bus.weak_cnt, exp_data, exp_weak);
        end
      end else if (bus.frame_data !== prev_data) begin
        miscompares++;
        $display("FAIL hold[%0d]: got frame_data=%h expected %h", n, bus.frame_data, prev_data);
      end
    end
  endtask

  task automatic fill_alternating();
    for (int n = 0; n < 32; n++) begin
      fi[n] = (n % 2 == 0) ? 4'sd4 : -4'sd4;
      fq[n] = (n % 2 == 0) ? 4'sd4 : -4'sd4;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.I_in = '0;
    bus.Q_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    heads(5, 1'b1);
    fill_alternating();
    send_frame(32, 64'd0, 64'hCCCC_CCCC_CCCC_CCCC, 7'd0);
  endtask

  task automatic test_rest_relock();
    idle(16, 4'sd4, -4'sd4);
    heads(5, 1'b1);
  endtask

  task automatic test_weak_frame();
    for (int n = 0; n < 32; n++) begin
      fi[n] = 4'sd1;
      fq[n] = -4'sd1;
    end
    send_frame(32, 64'hCCCC_CCCC_CCCC_CCCC, 64'hAAAA_AAAA_AAAA_AAAA, 7'd64);
    idle(16, 4'sd0, 4'sd0);
  endtask

  task automatic test_false_head();
    heads(4, 1'b0);
    idle(1, 4'sd0, 4'sd0);
    heads(5, 1'b1);
  endtask

  // Symbol 0 is (-8,+7); the rest are head-like and must be treated as data.
  task automatic test_extreme();
    fi[0] = -4'sd8;
    fq[0] = 4'sd7;
    for (int n = 1; n < 32; n++) begin
      fi[n] = 4'sd4;
      fq[n] = -4'sd4;
    end
    send_frame(32, 64'hAAAA_AAAA_AAAA_AAAA, 64'h6AAA_AAAA_AAAA_AAAA, 7'd0);
    idle(16, 4'sd0, 4'sd0);
  endtask

  task automatic test_reset_mid_frame();
    heads(5, 1'b1);
    fill_alternating();
    send_frame(20, 64'h6AAA_AAAA_AAAA_AAAA, 64'd0, 7'd0);
    reset = 1'b1;
    drive(4'sd4, 4'sd4);
    check_all_zero("mid_reset");
    reset = 1'b0;
    idle(11, 4'sd4, 4'sd4);
    vectors++;
    if (bus.frame_data !== 64'd0) begin
      miscompares++;
      $display("FAIL post_reset frame_data: got %h expected 0", bus.frame_data);
    end
    heads(5, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_rest_relock();
    test_weak_frame();
    test_false_head();
    test_extreme();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
